// File: rtl/joy_input_conditioner.sv
// joy_input_conditioner: debounces joystick buttons into one-cycle press pulses, with auto-repeat on the directions
module joy_input_conditioner #(
    parameter int TICK_DIV        = 50000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 400,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] joy_in,
    output logic [8:0]  held_out,
    output logic [8:0]  pulse_out
);
    localparam int RMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int RW = $clog2(RMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state;
    logic [8:0]    raw_q, stable, stable_q, rise, acc;
    logic [TW-1:0] pc;
    logic [DW-1:0] dc [9];
    logic [RW-1:0] rc;
    logic [1:0]    owner, new_owner;
    logic          tick, rep, unused_hi;

    assign unused_hi = ^joy_in[15:9];
    assign tick      = pc == TW'(TICK_DIV - 1);
    assign rise      = stable & ~stable_q;
    assign held_out  = stable;
    assign new_owner = rise[3] ? 2'd3 : rise[2] ? 2'd2 : rise[1] ? 2'd1 : 2'd0;
    // a new direction press or an owner release pre-empts a repeat landing in the same cycle
    assign rep = state != IDLE && rise[3:0] == 4'd0 && stable[owner] && tick &&
                 rc == RW'((state == DELAY ? REPEAT_DELAY_MS : REPEAT_RATE_MS) - 1);

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++)
            acc[i] = enable && tick && raw_q[i] != stable[i] && dc[i] == DW'(DEBOUNCE_MS - 1);
    end

    always_ff @(posedge clk) begin
        pc <= reset || tick ? '0 : pc + 1'b1;
        stable <= reset || !enable ? '0 : stable ^ acc;
        for (int i = 0; i < 9; i++)
            dc[i] <= reset || !enable || raw_q[i] == stable[i] || acc[i] ? '0 : tick ? dc[i] + 1'b1 : dc[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q     <= '0;
            stable_q  <= '0;
            pulse_out <= '0;
            state     <= IDLE;
            owner     <= '0;
            rc        <= '0;
        end else begin
            raw_q    <= joy_in[8:0];
            stable_q <= stable;
            // masking with the current pulse keeps every pulse exactly one cycle wide
            pulse_out <= enable ? (rise | (9'(rep) << owner)) & ~pulse_out : '0;
            if (!enable) begin
                state <= IDLE;
                rc    <= '0;
            end else if (rise[3:0] != 4'd0) begin
                state <= DELAY;
                owner <= new_owner;
                rc    <= '0;
            end else if (state != IDLE && !stable[owner]) begin
                state <= IDLE;
                rc    <= '0;
            end else if (rep) begin
                state <= REPEAT;
                rc    <= '0;
            end else if (state != IDLE && tick) begin
                rc <= rc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_joy_input_conditioner.sv
// tb_joy_input_conditioner: directed vectors and repeat/enable/reset sequences for joy_input_conditioner
module tb_joy_input_conditioner;
    logic        clk = 0, reset = 1, enable = 1;
    logic [15:0] joy_in = '0;
    logic [8:0]  held_out, pulse_out;
    logic [8:0]  prev_p = '0, prev_h = '0;
    int          cyc = 0, errors = 0, checks = 0, wide = 0;

    typedef struct {int c; int b; int k;} ev_t;
    typedef struct {string name; int b; int hi; int lo; int n; int pulses;} vec_t;
    ev_t evq[$];

    joy_input_conditioner #(
        .TICK_DIV(4), .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(10), .REPEAT_RATE_MS(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .joy_in(joy_in),
        .held_out(held_out), .pulse_out(pulse_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // event log: k=0 pulse, k=1 held rise, k=2 held fall, stamped with the edge count
    always @(negedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (pulse_out[i]) evq.push_back('{cyc, i, 0});
            if (pulse_out[i] && prev_p[i]) wide++;
            if (held_out[i] && !prev_h[i]) evq.push_back('{cyc, i, 1});
            if (!held_out[i] && prev_h[i]) evq.push_back('{cyc, i, 2});
        end
        prev_p = pulse_out;
        prev_h = held_out;
    end

    function automatic int cnt(int k, int b, int from, int to);
        int m = 0;
        foreach (evq[i])
            if (evq[i].k == k && (b < 0 || evq[i].b == b) && evq[i].c >= from && evq[i].c < to) m++;
        return m;
    endfunction

    function automatic int nth(int k, int b, int from, int n);
        int m = 0;
        foreach (evq[i])
            if (evq[i].k == k && evq[i].b == b && evq[i].c >= from) begin
                if (m == n) return evq[i].c;
                m++;
            end
        return -1;
    endfunction

    task automatic chk(string name, int act, int lo, int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[5];
        int c0, c1, c2, c3, p0, lp, lf, f, r, n;
        vt[0] = '{"action",  4, 100, 40, 1,  1};
        vt[1] = '{"bounce",  0, 6,   2,  10, 0};
        vt[2] = '{"glitch",  8, 5,   40, 1,  0};
        vt[3] = '{"chatter", 5, 8,   2,  4,  0};
        vt[4] = '{"loadmin", 7, 12,  40, 1,  1};

        step(3);
        chk("reset held", held_out, 0, 0);
        chk("reset pulse", pulse_out, 0, 0);
        reset = 0;
        step(5);

        foreach (vt[v]) begin
            c0 = cyc;
            repeat (vt[v].n) begin
                joy_in[vt[v].b] = 1'b1;
                step(vt[v].hi);
                joy_in[vt[v].b] = 1'b0;
                step(vt[v].lo);
            end
            step(40);
            chk({vt[v].name, " pulses"}, cnt(0, vt[v].b, c0, cyc + 1), vt[v].pulses, vt[v].pulses);
            chk({vt[v].name, " other"}, cnt(0, -1, c0, cyc + 1) - cnt(0, vt[v].b, c0, cyc + 1), 0, 0);
            chk({vt[v].name, " held end"}, held_out, 0, 0);
            if (vt[v].pulses > 0) begin
                r = nth(1, vt[v].b, c0, 0);
                chk({vt[v].name, " held rise"}, r - c0, 10, 14);
                chk({vt[v].name, " pulse lag"}, nth(0, vt[v].b, c0, 0) - r, 1, 1);
            end else
                chk({vt[v].name, " held never"}, cnt(1, vt[v].b, c0, cyc + 1), 0, 0);
        end

        // up held: press, delayed first repeat, fixed-rate repeats
        c0 = cyc;
        joy_in[3] = 1'b1;
        step(200);
        joy_in[3] = 1'b0;
        step(40);
        p0 = nth(0, 3, c0, 0);
        n = cnt(0, 3, c0, cyc + 1);
        chk("up press", p0 - c0, 11, 14);
        chk("up count", n, 10, 13);
        chk("up first repeat", nth(0, 3, c0, 1) - p0, 36, 44);
        for (int i = 2; i < n; i++) chk("up rate", nth(0, 3, c0, i) - nth(0, 3, c0, i - 1), 16, 16);
        f = nth(2, 3, c0, 0);
        chk("up after release", cnt(0, 3, f + 1, cyc + 1), 0, 0);
        chk("up others", cnt(0, -1, c0, cyc + 1) - n, 0, 0);

        // left takes ownership from a repeating up
        c0 = cyc;
        joy_in[3] = 1'b1;
        step(80);
        c1 = cyc;
        joy_in[1] = 1'b1;
        step(60);
        joy_in[3] = 1'b0;
        step(40);
        joy_in[1] = 1'b0;
        step(60);
        chk("up repeating", cnt(0, 3, c0, c1), 2, 3);
        lp = nth(0, 1, c1, 0);
        chk("left press", lp - c1, 11, 14);
        chk("left first repeat", nth(0, 1, c1, 1) - lp, 36, 44);
        chk("left rate", nth(0, 1, c1, 2) - nth(0, 1, c1, 1), 16, 16);
        chk("left rate after up release", nth(0, 1, c1, 3) - nth(0, 1, c1, 2), 16, 16);
        chk("up stops", cnt(0, 3, lp, cyc + 1), 0, 0);
        lf = nth(2, 1, c1, 0);
        chk("left idle", cnt(0, -1, lf + 1, cyc + 1), 0, 0);

        // simultaneous up+down: both press, only up repeats
        c0 = cyc;
        joy_in[3:2] = 2'b11;
        step(100);
        joy_in[3:2] = 2'b00;
        step(40);
        chk("both same cycle", nth(0, 2, c0, 0) - nth(0, 3, c0, 0), 0, 0);
        chk("down single", cnt(0, 2, c0, cyc + 1), 1, 1);
        chk("up repeats", cnt(0, 3, c0, cyc + 1), 4, 6);

        // enable drop, re-debounce, then reset mid-repeat
        c0 = cyc;
        joy_in[0] = 1'b1;
        step(30);
        chk("right press", cnt(0, 0, c0, cyc + 1), 1, 1);
        enable = 1'b0;
        c1 = cyc;
        step(3);
        chk("disabled held", held_out, 0, 0);
        chk("disabled pulse", pulse_out, 0, 0);
        step(17);
        enable = 1'b1;
        c2 = cyc;
        chk("disabled no pulse", cnt(0, -1, c1, c2 + 1), 0, 0);
        step(60);
        r = nth(0, 0, c2, 0);
        chk("reenable press", r - c2, 10, 14);
        chk("reenable repeat", nth(0, 0, c2, 1) - r, 36, 44);
        reset = 1'b1;
        joy_in = '0;
        step(1);
        chk("midreset held", held_out, 0, 0);
        chk("midreset pulse", pulse_out, 0, 0);
        c3 = cyc;
        reset = 1'b0;
        step(60);
        chk("no pulse after reset", cnt(0, -1, c3, cyc + 1), 0, 0);
        chk("pulse width", wide, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
